// File: rtl/ack_bus_scheduler.sv
// Registered one-hot arbiter for the shared ack bus (MEM/SHA/AES/CTRL) with a bounded hold timer.
// Define ACK_SCHED_RR_EN for round-robin selection; otherwise fixed priority, lowest ID first.
module ack_bus_scheduler #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_mem,
  input  logic       req_sha,
  input  logic       req_aes,
  input  logic       req_ctrl,
  output logic       ack_ready_to_mem,
  output logic       ack_ready_to_sha,
  output logic       ack_ready_to_aes,
  output logic       ack_ready_to_ctrl,
  output logic [1:0] winner_source_id,
  output logic       ack_event,
  output logic       ack_timeout,
  output logic       busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam bit         TO_EN    = (HOLD_MAX != 0);
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] ready_q, ready_d;
  logic [1:0] winner_q, winner_d;
  logic       event_q, event_d;
  logic       timeout_q, timeout_d;
  logic [3:0] penalty_q, penalty_d;
  logic [7:0] hold_q, hold_d;

  logic [3:0] req;
  logic [3:0] elig;
  logic [1:0] pick;
  logic       owner_req;

  assign req       = {req_ctrl, req_aes, req_sha, req_mem};
  assign elig      = req & ~penalty_q;
  assign owner_req = req[winner_q];

`ifdef ACK_SCHED_RR_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;

  // Search begins just after the last winner and wraps, so the last winner is tried last.
  function automatic logic [1:0] pick_winner(input logic [3:0] e, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    pick_winner = 2'd0;
    found       = 1'b0;
    for (int k = 1; k < 5; k++) begin
      idx = p + k[1:0];
      if (!found && e[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

  assign pick = pick_winner(elig, rr_ptr_q);
`else
  function automatic logic [1:0] pick_winner(input logic [3:0] e);
    if (e[0])      pick_winner = 2'd0;
    else if (e[1]) pick_winner = 2'd1;
    else if (e[2]) pick_winner = 2'd2;
    else           pick_winner = 2'd3;
  endfunction

  assign pick = pick_winner(elig);
`endif

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    winner_d  = winner_q;
    event_d   = 1'b0;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    // A penalty lasts only until the source is seen with its request dropped.
    penalty_d = penalty_q & req;
`ifdef ACK_SCHED_RR_EN
    rr_ptr_d  = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        ready_d = 4'b0000;
        if (|elig) begin
          state_d  = S_GRANT;
          ready_d  = 4'b0001 << pick;
          winner_d = pick;
          event_d  = 1'b1;
          hold_d   = 8'd0;
`ifdef ACK_SCHED_RR_EN
          rr_ptr_d = pick;
`endif
        end
      end
      S_GRANT: begin
        // A release requested on the limit cycle wins over the timeout.
        if (!owner_req) begin
          state_d = S_RELEASE;
          ready_d = 4'b0000;
        end else if (TO_EN && (hold_q == HOLD_LIM)) begin
          state_d             = S_RELEASE;
          ready_d             = 4'b0000;
          timeout_d           = 1'b1;
          penalty_d[winner_q] = 1'b1;
        end else begin
          hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
        end
      end
      S_RELEASE: begin
        ready_d = 4'b0000;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 4'b0000;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ready_q   <= 4'b0000;
      winner_q  <= 2'd0;
      event_q   <= 1'b0;
      timeout_q <= 1'b0;
      penalty_q <= 4'b0000;
      hold_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      winner_q  <= winner_d;
      event_q   <= event_d;
      timeout_q <= timeout_d;
      penalty_q <= penalty_d;
      hold_q    <= hold_d;
    end
  end

`ifdef ACK_SCHED_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= 2'b11;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  assign ack_ready_to_mem  = ready_q[0];
  assign ack_ready_to_sha  = ready_q[1];
  assign ack_ready_to_aes  = ready_q[2];
  assign ack_ready_to_ctrl = ready_q[3];
  assign winner_source_id  = winner_q;
  assign ack_event         = event_q;
  assign ack_timeout       = timeout_q;
  assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_ack_bus_scheduler.sv
// Scoreboard bench for ack_bus_scheduler (HOLD_MAX=4): expected grant IDs queued by stimulus,
// popped by a monitor on every ack_event.
module tb_ack_bus_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       r_mem, r_sha, r_aes, r_ctrl;
  logic [1:0] winner;
  logic       ack_event, ack_timeout, busy;
  logic [3:0] rdy;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int to_exp = 0;
  int to_seen = 0;
  int e;

  assign rdy = {r_ctrl, r_aes, r_sha, r_mem};

  ack_bus_scheduler #(.HOLD_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req_mem(req[0]), .req_sha(req[1]), .req_aes(req[2]), .req_ctrl(req[3]),
    .ack_ready_to_mem(r_mem), .ack_ready_to_sha(r_sha),
    .ack_ready_to_aes(r_aes), .ack_ready_to_ctrl(r_ctrl),
    .winner_source_id(winner), .ack_event(ack_event),
    .ack_timeout(ack_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int id, input string name);
    int n = 0;
    while (rdy[id] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(name, int'(rdy[id]), 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  // Monitor: grant identity on each ack_event, ownership consistency every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rdy != 4'b0000)
        check("ready_owner", int'(rdy), int'(4'b0001 << winner));
      if (ack_event === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_grant: got id %0d, expected none", winner);
        end else begin
          e = exp_q.pop_front();
          check("grant_id", int'(winner), e);
          check("grant_ready", int'(rdy), 1 << e);
        end
      end
      if (ack_timeout === 1'b1) to_seen++;
    end
  end

  initial begin
    int gap;
    int n;
    rst = 1'b1;
    req = 4'b0000;
    repeat (3) tick();
    check("rst_ready", int'(rdy), 0);
    check("rst_winner", int'(winner), 0);
    check("rst_event", int'(ack_event), 0);
    check("rst_timeout", int'(ack_timeout), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick();

    // Single SHA request
    req[1] = 1'b1;
    exp_q.push_back(1);
    tick();
    check("sha_ready", int'(rdy), 4'b0010);
    check("sha_winner", int'(winner), 1);
    check("sha_event", int'(ack_event), 1);
    tick();
    check("sha_event_once", int'(ack_event), 0);
    check("sha_ready_hold", int'(rdy), 4'b0010);
    req[1] = 1'b0;
    tick();
    check("sha_release", int'(rdy), 0);
    check("sha_busy_release", int'(busy), 1);
    tick();
    check("sha_busy_idle", int'(busy), 0);

    // All four requesting: MEM, SHA, AES, CTRL with 2-cycle gaps
    req = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    wait_ready(0, "all_first_mem");
    for (int i = 0; i < 4; i++) begin
      check("all_event", int'(ack_event), 1);
      tick();
      req[i] = 1'b0;
      if (i < 3) begin
        gap = 0;
        tick();
        while (rdy == 4'b0000 && gap < 10) begin
          gap++;
          tick();
        end
        check("all_gap", gap, 2);
        check("all_next_owner", int'(rdy), 1 << (i + 1));
      end
    end
    wait_idle("all_idle");

    // MEM re-requests right after release while SHA waits
    req = 4'b0011;
    exp_q.push_back(0);
    wait_ready(0, "fair_mem");
    tick();
    req[0] = 1'b0;
    tick();
    req[0] = 1'b1;
`ifdef ACK_SCHED_RR_EN
    exp_q.push_back(1);
`else
    exp_q.push_back(0);
`endif
    n = 0;
    while (rdy == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    check("fair_regrant", int'(rdy != 4'b0000), 1);
    req = 4'b0000;
    wait_idle("fair_idle");

    // AES held forever times out, CTRL follows, AES penalised
    req = 4'b1100;
    exp_q.push_back(2);
    exp_q.push_back(3);
    to_exp++;
    wait_ready(2, "to_aes_grant");
    n = 0;
    while (rdy[2] === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check("to_aes_len", n, 4);
    check("to_pulse", int'(ack_timeout), 1);
    check("to_release", int'(rdy), 0);
    wait_ready(3, "to_ctrl_grant");
    tick();
    req[3] = 1'b0;
    wait_idle("to_ctrl_idle");
    repeat (6) tick();
    check("to_aes_penalised", int'(rdy), 0);
    check("to_aes_penalised_busy", int'(busy), 0);
    req[2] = 1'b0;
    tick();
    req[2] = 1'b1;
    exp_q.push_back(2);
    wait_ready(2, "to_aes_regrant");
    req[2] = 1'b0;
    wait_idle("to_aes_idle");

    // Owner drops on its 4th ready cycle: normal release
    req[0] = 1'b1;
    exp_q.push_back(0);
    wait_ready(0, "edge_mem_grant");
    repeat (3) tick();
    check("edge_mem_4th", int'(rdy), 4'b0001);
    req[0] = 1'b0;
    tick();
    check("edge_release", int'(rdy), 0);
    check("edge_no_timeout", int'(ack_timeout), 0);
    req[0] = 1'b1;
    exp_q.push_back(0);
    wait_ready(0, "edge_no_penalty");

    // Asynchronous reset mid-grant
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", int'(rdy), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_winner", int'(winner), 0);
    check("arst_event", int'(ack_event), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(0);
    wait_ready(0, "arst_regrant");
    check("arst_fresh_event", int'(ack_event), 1);
    req = 4'b0000;
    wait_idle("arst_idle");

    repeat (3) tick();
    check("pending_grants", exp_q.size(), 0);
    check("timeout_count", to_seen, to_exp);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ack_bus_scheduler.md
# ack_bus_scheduler

Sequential arbiter that shares the single ack bus between the MEM, SHA, AES and CTRL sources. It replaces the purely combinational wired-AND resolution with registered, one-hot grants held for the owner's whole transaction. It adds a bounded hold timer and, optionally, round-robin fairness. It sits between the four source modules and the ack bus consumers, and drives the same ready/winner/event signals they already use.

## Interface
- `HOLD_MAX`, default 16: maximum cycles an owner may hold the grant (1..255); 0 disables the timeout.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_mem`, `req_sha`, `req_aes`, `req_ctrl` input 1 each: level requests; held high until granted and for the whole transaction.
- `ack_ready_to_mem`, `ack_ready_to_sha`, `ack_ready_to_aes`, `ack_ready_to_ctrl` output 1 each: registered one-hot grant.
- `winner_source_id` output 2: ID of current or most recent owner (MEM=00, SHA=01, AES=10, CTRL=11).
- `ack_event` output 1: one-cycle pulse, coincident with the first cycle of a new grant.
- `ack_timeout` output 1: one-cycle pulse when a grant is revoked by the hold timer.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- **IDLE**
  - Eligible set = requests AND NOT penalty mask.
  - If non-empty, select winner → GRANT: set that ready bit, load `winner_source_id`, pulse `ack_event`, clear hold counter.
  - Otherwise stay in IDLE.
- **GRANT**
  - Ready stays high while the owner's req is high; hold counter increments each cycle (8-bit, saturating).
  - Owner req low → RELEASE, normal release, no timeout.
  - `HOLD_MAX`≠0 and counter reaches `HOLD_MAX`−1 with req still high → RELEASE, pulse `ack_timeout`, set the owner's penalty bit.
  - If the owner drops req in the same cycle the limit is reached, treat it as a normal release (no timeout, no penalty).
  - Requests from non-owners are ignored while in GRANT.
- **RELEASE**
  - All ready bits low for exactly one cycle (bus turnaround), then → IDLE.
- Penalty bit
  - Cleared when that source's req is sampled low.
  - A timed-out source must drop req before it is eligible again.
- Selection: see Configuration. Ready outputs are never more than one-hot; all are zero in IDLE and RELEASE.

## Timing
- Reset values: all ready 0, `winner_source_id`=00, `ack_event`=0, `ack_timeout`=0, `busy`=0, state IDLE, penalty mask 0, hold counter 0, RR pointer 11.
- Grant latency: req sampled high in IDLE at edge N → ready high and `ack_event` high after edge N.
- Maximum grant length: exactly `HOLD_MAX` cycles of ready high.
- Release: owner req sampled low at edge M → ready low after edge M.
- Minimum gap between two grants: 2 cycles (RELEASE + IDLE sample).
- `rst` asserted mid-grant: all outputs go to reset values immediately (asynchronously); no `ack_event` or `ack_timeout` is emitted.

## Configuration
- `ACK_SCHED_RR_EN` defined:
  - Round-robin selection. Search starts at (pointer+1) mod 4 and increases by ID.
  - Pointer ← winner ID on every grant.
- Not defined:
  - Fixed priority MEM > SHA > AES > CTRL (lowest ID wins, matching wired-AND bus resolution). Pointer logic absent.

## Test plan
- Reset, then `req_sha`=1 alone → next cycle `ack_ready_to_sha`=1, `winner_source_id`=01, `ack_event` pulses once. Drop req → ready low next cycle, `busy` low 1 cycle later.
- All four requests held high (macro off) → grants in order MEM, SHA, AES, CTRL as each owner drops req. Each grant is separated by exactly 2 idle-ready cycles.
- Same stimulus with `ACK_SCHED_RR_EN`, MEM re-requesting immediately after release → grant order MEM, SHA, AES, CTRL, MEM.
- `HOLD_MAX`=4, `req_aes` held forever, `req_ctrl` high:
  - AES ready high exactly 4 cycles, then `ack_timeout` pulses and CTRL is granted.
  - AES is not re-granted until its req goes low then high again.
- `HOLD_MAX`=4, owner drops req on its 4th ready cycle → normal release, `ack_timeout` stays 0, no penalty.
- `rst` pulsed while MEM is granted → ready, `busy`, `winner_source_id` zero immediately. After reset, MEM is re-granted with a fresh `ack_event`.
